segdisp_signed: RTL and testbench
=================================

# segdisp_signed

Parametrised signed-integer to multi-digit 7-segment display driver. Accepts a two's-complement value through a valid/ready handshake. Converts its magnitude to BCD sequentially (shift-and-add-3, one bit per cycle), then registers active-low segment patterns for a sign digit and DIGITS numeric digits. It sits between any result-producing block (angle estimator, level meter) and the board's HEX displays, and replaces fixed-width, fixed-step display logic.

## Interface
- WIDTH, 8, bit width of signed input value (4..24)
- DIGITS, 3, number of numeric 7-seg digits driven (1..8)
- STALE_CYCLES, 50_000_000, idle cycles before display is marked stale (only with SEGDISP_STALE_EN)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  value present
- in_ready  out  1  block can accept a value (high only in IDLE)
- value  in  WIDTH  signed two's-complement input
- seg  out  7*DIGITS  active-low segments {g,f,e,d,c,b,a} per digit; digit 0 in bits [6:0] is least significant
- sign_seg  out  7  active-low sign digit
- done  out  1  one-cycle pulse when seg/sign_seg update
- overflow  out  1  last accepted value did not fit in DIGITS
- stale  out  1  no update within STALE_CYCLES (0 when feature compiled out)

## Operation
- Codes (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, DASH=0111111, BLANK=1111111.
- Handshake: accept on the edge where in_valid && in_ready. Value and sign are captured only then. in_valid while busy is ignored, with no queueing.
- Magnitude: mag = value[WIDTH-1] ? -value : value, held as WIDTH-bit unsigned. The most negative value -2^(WIDTH-1) gives mag = 2^(WIDTH-1) correctly.
- Internal BCD width NBCD = WIDTH*3/10 + 1 digits (integer division).
- FSM:
  - IDLE: in_ready=1. On accept, load mag, clear BCD, clear bit counter, go to CONV.
  - CONV: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,mag} left 1. After WIDTH shifts, go to ENCODE.
  - ENCODE: write outputs, pulse done, return to IDLE.
- Encoding:
  - overflow = any BCD digit at index ≥ DIGITS is nonzero. On overflow, all seg digits show DASH; sign_seg still shows sign.
  - Otherwise, leading-zero digits show BLANK. Digit 0 is always shown, so zero displays as "0".
  - sign_seg = DASH if the value is negative, BLANK otherwise. Zero is never negative.
- Reset (any state, including mid-CONV): aborts conversion, state IDLE.
  - Reset output values: seg all DASH, sign_seg DASH, done 0, overflow 0, stale 0, in_ready 1 from the first cycle after reset.

## Timing
- Accept at edge T. CONV occupies edges T+1..T+WIDTH. Outputs and done update at edge T+WIDTH+1.
- Latency is WIDTH+1 cycles. in_ready is high again in the cycle after done.
- Back-to-back throughput: one value per WIDTH+2 cycles.
- seg, sign_seg and overflow hold between updates. They change only at ENCODE or reset.

## Configuration
- SEGDISP_STALE_EN defined:
  - Counter of STALE_CYCLES width is cleared at each done and saturates at STALE_CYCLES.
  - On reaching STALE_CYCLES, stale goes to 1. seg and sign_seg then read as all DASH; the stored value is retained internally.
  - stale returns to 0 and the real value is shown at the next done.
  - Reset clears the counter.
- Undefined: no counter, stale tied 0, outputs always show the last stored value.

## Structure
- Package segdisp_pkg holds:
  - SEG_DIGIT[10], SEG_DASH and SEG_BLANK constants
  - function seg7_of(logic [3:0])
  - state enum {IDLE, CONV, ENCODE}
- One sub-module, bin2bcd_seq: start/done iterative double-dabble, parameters WIDTH and NBCD. The top holds the handshake, sign, encoding and stale logic.

## Test plan
- WIDTH=8, DIGITS=3, value=-90 → after 9 cycles: sign DASH, digits BLANK/9/0, done pulse, overflow 0.
- value=0 → sign BLANK, digits BLANK/BLANK/0. value=-128 → sign DASH, digits 1/2/8.
- WIDTH=12, DIGITS=3, value=2047 → overflow 1, all digits DASH, sign BLANK. Then value=-999 → overflow 0, digits 9/9/9.
- Hold in_valid high continuously with varying values → exactly one accept per 10 cycles. Values presented while in_ready=0 are never displayed.
- Assert reset at CONV cycle 4 → next cycle all outputs DASH, in_ready 1. A new value then converts normally.
- With SEGDISP_STALE_EN and STALE_CYCLES=20: display 45, idle 20 cycles → stale 1, all DASH. Send 5 → stale 0, digits BLANK/BLANK/5.

Source files
------------

// File: rtl/segdisp_pkg.sv
// Shared constants, state encoding and segment lookup for the signed 7-segment display driver.
package segdisp_pkg;

  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    ENCODE = 2'd2
  } state_t;

  // Non-decimal nibbles cannot come out of the converter; they fall back to a dash.
  function automatic logic [6:0] seg7_of(input logic [3:0] d);
    case (d)
      4'd0:    seg7_of = SEG_DIGIT[0];
      4'd1:    seg7_of = SEG_DIGIT[1];
      4'd2:    seg7_of = SEG_DIGIT[2];
      4'd3:    seg7_of = SEG_DIGIT[3];
      4'd4:    seg7_of = SEG_DIGIT[4];
      4'd5:    seg7_of = SEG_DIGIT[5];
      4'd6:    seg7_of = SEG_DIGIT[6];
      4'd7:    seg7_of = SEG_DIGIT[7];
      4'd8:    seg7_of = SEG_DIGIT[8];
      4'd9:    seg7_of = SEG_DIGIT[9];
      default: seg7_of = SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/segdisp_signed_bin2bcd_seq.sv
// Iterative shift-and-add-3 binary to BCD converter, one input bit per cycle.
// done is high during the cycle whose closing edge performs the final shift.
module bin2bcd_seq #(
  parameter int WIDTH = 8,
  parameter int NBCD  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                done,
  output logic [4*NBCD-1:0]   bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]  shreg_r;
  logic [4*NBCD-1:0] bcd_r;
  logic [4*NBCD-1:0] adj_s;
  logic [CW-1:0]     cnt_r;
  logic              busy_r;

  // add-3 correction of every nibble that would reach 10 or more after the shift
  always_comb begin
    adj_s = bcd_r;
    for (int i = 0; i < NBCD; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
      else                         adj_s[4*i +: 4] = bcd_r[4*i +: 4];
    end
  end

  // load on start, then one corrected shift per cycle for WIDTH cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_r <= '0;
      bcd_r   <= '0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
    end else if (start) begin
      shreg_r <= bin;
      bcd_r   <= '0;
      cnt_r   <= '0;
      busy_r  <= 1'b1;
    end else if (busy_r) begin
      {bcd_r, shreg_r} <= {adj_s[4*NBCD-2:0], shreg_r, 1'b0};
      cnt_r            <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      busy_r           <= (cnt_r != CW'(WIDTH - 1));
    end
  end

  assign done = busy_r && (cnt_r == CW'(WIDTH - 1));
  assign bcd  = bcd_r;

endmodule

// File: rtl/segdisp_signed.sv
// Signed value to multi-digit active-low 7-segment driver with valid/ready input.
// Define SEGDISP_STALE_EN to blank the display with dashes after STALE_CYCLES idle cycles.
module segdisp_signed
  import segdisp_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DIGITS       = 3,
  parameter int STALE_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      value,
  output logic [7*DIGITS-1:0]   seg,
  output logic [6:0]            sign_seg,
  output logic                  done,
  output logic                  overflow,
  output logic                  stale
);

  localparam int NBCD = WIDTH * 3 / 10 + 1;
  localparam int MAXD = (NBCD > DIGITS) ? NBCD : DIGITS;

  state_t              state_r;
  logic                neg_r;
  logic [7*DIGITS-1:0] seg_r;
  logic [6:0]          sign_r;
  logic                done_r;
  logic                ovf_r;

  logic                accept_s;
  logic [WIDTH-1:0]    mag_s;
  logic                conv_last_s;
  logic [4*NBCD-1:0]   bcd_s;
  logic [4*MAXD-1:0]   bcd_ext_s;
  logic [7*DIGITS-1:0] enc_s;
  logic                ovf_s;
  logic                lead_s;
  logic [3:0]          dig_s;

  assign accept_s = in_valid && (state_r == IDLE);
  // Plain two's-complement negate: the most negative input wraps to 2^(WIDTH-1) as unsigned.
  assign mag_s    = value[WIDTH-1] ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

  bin2bcd_seq #(.WIDTH(WIDTH), .NBCD(NBCD)) u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (accept_s),
    .bin   (mag_s),
    .done  (conv_last_s),
    .bcd   (bcd_s)
  );

  // overflow detection and leading-zero blanking of the finished BCD digits
  always_comb begin
    bcd_ext_s               = '0;
    bcd_ext_s[4*NBCD-1:0]   = bcd_s;
    ovf_s                   = 1'b0;
    for (int i = DIGITS; i < MAXD; i++) ovf_s = ovf_s | (bcd_ext_s[4*i +: 4] != 4'd0);
    enc_s  = '1;
    lead_s = 1'b1;
    dig_s  = 4'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dig_s = bcd_ext_s[4*i +: 4];
      if (lead_s && (dig_s == 4'd0) && (i != 0)) begin
        enc_s[7*i +: 7] = SEG_BLANK;
      end else begin
        enc_s[7*i +: 7] = seg7_of(dig_s);
        lead_s          = 1'b0;
      end
    end
  end

  // control FSM and the display registers it updates in ENCODE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      neg_r   <= 1'b0;
      seg_r   <= {DIGITS{SEG_DASH}};
      sign_r  <= SEG_DASH;
      done_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            neg_r   <= value[WIDTH-1];
            state_r <= CONV;
          end
        end
        CONV: begin
          if (conv_last_s) state_r <= ENCODE;
        end
        ENCODE: begin
          seg_r   <= ovf_s ? {DIGITS{SEG_DASH}} : enc_s;
          sign_r  <= neg_r ? SEG_DASH : SEG_BLANK;
          ovf_r   <= ovf_s;
          done_r  <= 1'b1;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign in_ready = (state_r == IDLE);
  assign done     = done_r;
  assign overflow = ovf_r;

`ifdef SEGDISP_STALE_EN
  localparam int SCW = $clog2(STALE_CYCLES + 1);

  logic [SCW-1:0] stale_cnt_r;
  logic           stale_r;

  // idle timer: restarts at each display update, saturates and latches stale at its limit
  always_ff @(posedge clk) begin
    if (reset) begin
      stale_cnt_r <= '0;
      stale_r     <= 1'b0;
    end else if (state_r == ENCODE) begin
      stale_cnt_r <= '0;
      stale_r     <= 1'b0;
    end else if (stale_cnt_r != SCW'(STALE_CYCLES)) begin
      stale_cnt_r <= stale_cnt_r + {{(SCW-1){1'b0}}, 1'b1};
      stale_r     <= (stale_cnt_r == SCW'(STALE_CYCLES - 1));
    end
  end

  // Stored digits stay in seg_r; only the visible copy is masked while stale.
  assign stale    = stale_r;
  assign seg      = stale_r ? {DIGITS{SEG_DASH}} : seg_r;
  assign sign_seg = stale_r ? SEG_DASH : sign_r;
`else
  logic unused_stale_s;
  assign unused_stale_s = ^32'(STALE_CYCLES);
  assign stale          = 1'b0;
  assign seg            = seg_r;
  assign sign_seg       = sign_r;
`endif

endmodule

// File: tb/tb_segdisp_signed.sv
// Directed self-checking bench for segdisp_signed: an 8-bit and a 12-bit instance, 3 digits each.
module tb_segdisp_signed;

  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100, D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001, D5 = 7'b0010010, D7 = 7'b1111000;
  localparam logic [6:0] D8 = 7'b0000000, D9 = 7'b0010000;

  logic        clk = 1'b0;
  logic        reset8, reset12;
  logic        vld8, vld12, rdy8, rdy12;
  logic [7:0]  v8;
  logic [11:0] v12;
  logic [20:0] seg8, seg12;
  logic [6:0]  sign8, sign12;
  logic        done8, done12, ovf8, ovf12, stale8, stale12;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  segdisp_signed #(.WIDTH(8), .DIGITS(3), .STALE_CYCLES(20)) dut8 (
    .clk(clk), .reset(reset8), .in_valid(vld8), .in_ready(rdy8), .value(v8),
    .seg(seg8), .sign_seg(sign8), .done(done8), .overflow(ovf8), .stale(stale8)
  );

  segdisp_signed #(.WIDTH(12), .DIGITS(3), .STALE_CYCLES(20)) dut12 (
    .clk(clk), .reset(reset12), .in_valid(vld12), .in_ready(rdy12), .value(v12),
    .seg(seg12), .sign_seg(sign12), .done(done12), .overflow(ovf12), .stale(stale12)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] code(input int d);
    case (d)
      0: code = 7'b1000000;  1: code = 7'b1111001;  2: code = 7'b0100100;
      3: code = 7'b0110000;  4: code = 7'b0011001;  5: code = 7'b0010010;
      6: code = 7'b0000010;  7: code = 7'b1111000;  8: code = 7'b0000000;
      9: code = 7'b0010000;
      default: code = 7'b0111111;
    endcase
  endfunction

  // Reference display of an 8-bit value via decimal arithmetic.
  function automatic logic [20:0] model8(input int v);
    int m;
    int d [3];
    logic [20:0] r;
    bit lead;
    m = (v < 0) ? -v : v;
    d[0] = m % 10; d[1] = (m / 10) % 10; d[2] = (m / 100) % 10;
    lead = 1'b1;
    r = '1;
    for (int i = 2; i >= 0; i--) begin
      if (lead && d[i] == 0 && i != 0) r[7*i +: 7] = BLANK;
      else begin r[7*i +: 7] = code(d[i]); lead = 1'b0; end
    end
    return r;
  endfunction

  task automatic send8(input logic [7:0] v);
    int n;
    n = 0;
    while (!rdy8 && n < 50) begin @(posedge clk); #1; n++; end
    check("ready8", rdy8, 1);
    v8 = v; vld8 = 1'b1;
    @(posedge clk); #1;
    vld8 = 1'b0;
    n = 0;
    while (!done8 && n < 50) begin @(posedge clk); #1; n++; end
    check("latency8", n, 9);
  endtask

  task automatic send12(input logic [11:0] v);
    int n;
    n = 0;
    while (!rdy12 && n < 50) begin @(posedge clk); #1; n++; end
    check("ready12", rdy12, 1);
    v12 = v; vld12 = 1'b1;
    @(posedge clk); #1;
    vld12 = 1'b0;
    n = 0;
    while (!done12 && n < 50) begin @(posedge clk); #1; n++; end
    check("latency12", n, 13);
  endtask

  initial begin
    int nacc, ndone, prev_i, pend, n;
    reset8 = 1'b1; reset12 = 1'b1; vld8 = 1'b0; vld12 = 1'b0; v8 = 8'd0; v12 = 12'd0;
    repeat (2) @(posedge clk);
    #1;
    reset8 = 1'b0; reset12 = 1'b0;

    check("rst_seg",   seg8,  {DASH, DASH, DASH});
    check("rst_sign",  sign8, DASH);
    check("rst_done",  done8, 0);
    check("rst_ovf",   ovf8,  0);
    check("rst_stale", stale8, 0);
    check("rst_ready", rdy8,  1);

    send8(8'hA6);  // -90
    check("m90_seg",  seg8,  {BLANK, D9, D0});
    check("m90_sign", sign8, DASH);
    check("m90_ovf",  ovf8,  0);
    check("m90_rdy",  rdy8,  1);
    @(posedge clk); #1;
    check("done_pulse", done8, 0);
    check("hold_seg",   seg8,  {BLANK, D9, D0});

    send8(8'h00);
    check("zero_seg",  seg8,  {BLANK, BLANK, D0});
    check("zero_sign", sign8, BLANK);

    send8(8'h80);  // -128
    check("m128_seg",  seg8,  {D1, D2, D8});
    check("m128_sign", sign8, DASH);

    send8(8'h7F);
    check("p127_seg",  seg8,  {D1, D2, D7});
    check("p127_sign", sign8, BLANK);

    send8(8'hFF);  // -1
    check("m1_seg",  seg8,  {BLANK, BLANK, D1});
    check("m1_sign", sign8, DASH);

    send8(8'd100);
    check("p100_seg", seg8, {D1, D0, D0});

    send12(12'h7FF);  // 2047
    check("w12_ovf",  ovf12,  1);
    check("w12_seg",  seg12,  {DASH, DASH, DASH});
    check("w12_sign", sign12, BLANK);
    send12(12'hC19);  // -999
    check("w12_m999_ovf",  ovf12,  0);
    check("w12_m999_seg",  seg12,  {D9, D9, D9});
    check("w12_m999_sign", sign12, DASH);
    send12(12'h800);  // -2048
    check("w12_m2048_ovf",  ovf12,  1);
    check("w12_m2048_sign", sign12, DASH);

    // in_valid held high with a new value every cycle
    @(posedge clk); #1;
    vld8 = 1'b1; nacc = 0; ndone = 0; prev_i = -1; pend = 0;
    for (int i = 0; i < 45; i++) begin
      if (done8) begin
        ndone++;
        check("b2b_seg",  seg8,  model8(pend));
        check("b2b_sign", sign8, (pend < 0) ? DASH : BLANK);
      end
      v8 = 8'(i * 29 - 60);
      if (rdy8) begin
        if (nacc > 0) check("b2b_gap", i - prev_i, 10);
        pend = int'($signed(v8));
        prev_i = i;
        nacc++;
      end
      @(posedge clk); #1;
    end
    vld8 = 1'b0;
    check("b2b_accepts", nacc, 5);
    check("b2b_dones",   ndone, 4);
    n = 0;
    while (!done8 && n < 30) begin @(posedge clk); #1; n++; end
    check("b2b_last_seg", seg8, model8(pend));

    // reset during the fourth CONV cycle
    @(posedge clk); #1;
    v8 = 8'd77; vld8 = 1'b1;
    @(posedge clk); #1;
    vld8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset8 = 1'b1;
    @(posedge clk); #1;
    reset8 = 1'b0;
    check("mid_rst_seg",   seg8,  {DASH, DASH, DASH});
    check("mid_rst_sign",  sign8, DASH);
    check("mid_rst_ready", rdy8,  1);
    check("mid_rst_done",  done8, 0);
    check("mid_rst_ovf",   ovf8,  0);
    send8(8'd42);
    check("after_rst_seg",  seg8,  {BLANK, D4, D2});
    check("after_rst_sign", sign8, BLANK);

    send8(8'd45);
    check("p45_seg", seg8, {BLANK, D4, D5});
`ifdef SEGDISP_STALE_EN
    repeat (19) begin @(posedge clk); #1; end
    check("stale_early", stale8, 0);
    @(posedge clk); #1;
    check("stale_set",      stale8, 1);
    check("stale_seg",      seg8,   {DASH, DASH, DASH});
    check("stale_sign",     sign8,  DASH);
    send8(8'd5);
    check("stale_clear",    stale8, 0);
    check("stale_new_seg",  seg8,   {BLANK, BLANK, D5});
    check("stale_new_sign", sign8,  BLANK);
`else
    repeat (25) begin @(posedge clk); #1; end
    check("no_stale",     stale8, 0);
    check("no_stale_seg", seg8,   {BLANK, D4, D5});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
